// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central hazard and trap sequencer for the 5-stage core.
// Generates fetch/decode stall and flush, the load-use interlock and trap/branch redirects.
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef ILLEGAL
`define ILLEGAL 0
`endif
`ifndef ECALL
`define ECALL 1
`endif
`ifndef EBREAK
`define EBREAK 2
`endif
`ifndef MRET
`define MRET 3
`endif

module pipeline_ctrl #(
    parameter int AWIDTH = 5,
    parameter int PC_WIDTH = 32,
    parameter int LOAD_LAT = 2,
    parameter int INFLIGHT_W = 3,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                        d_clk,
    input  logic                        d_rst,
    input  logic                        i_dec_ce,
    input  logic [AWIDTH-1:0]           i_dec_rs1,
    input  logic [AWIDTH-1:0]           i_dec_rs2,
    input  logic [`EXCEPTION_WIDTH-1:0] i_dec_exc,
    input  logic [PC_WIDTH-1:0]         i_dec_pc,
    input  logic                        i_ex_issue,
    input  logic                        i_ex_load,
    input  logic [AWIDTH-1:0]           i_ex_rd,
    input  logic                        i_ex_br_taken,
    input  logic [PC_WIDTH-1:0]         i_ex_target,
    input  logic                        i_wb_retire,
    output logic                        o_stall,
    output logic                        o_flush,
    output logic                        o_redirect,
    output logic [PC_WIDTH-1:0]         o_redirect_pc,
    output logic [PC_WIDTH-1:0]         o_epc,
    output logic [3:0]                  o_cause,
    output logic                        o_busy
);

    typedef enum logic [1:0] {RUN, LSTALL, DRAIN, TRAP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t                state, state_next;
    logic [2:0]            stall_cnt, stall_cnt_next;
    logic [INFLIGHT_W-1:0] inflight;
    logic [PC_WIDTH-1:0]   epc_next;
    logic [3:0]            cause_next;
    logic                  is_mret, is_mret_next;
    logic                  stall, flush, redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  exc_trap, exc_any, hazard;

    assign exc_trap = i_dec_exc[`ILLEGAL] | i_dec_exc[`ECALL] | i_dec_exc[`EBREAK];
    assign exc_any  = exc_trap | i_dec_exc[`MRET];
    assign hazard   = i_dec_ce && i_ex_load && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_dec_rs1) || (i_ex_rd == i_dec_rs2));

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            o_epc     <= '0;
            o_cause   <= '0;
            is_mret   <= 1'b0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
            o_epc     <= epc_next;
            o_cause   <= cause_next;
            is_mret   <= is_mret_next;
        end
    end

    // Saturating count of instructions between execute and writeback.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            inflight <= '0;
        end else begin
            case ({i_ex_issue, i_wb_retire})
                2'b10:   if (inflight != '1) inflight <= inflight + 1'b1;
                2'b01:   if (inflight != '0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        epc_next       = o_epc;
        cause_next     = o_cause;
        is_mret_next   = is_mret;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        case (state)
            RUN: begin
                if (i_ex_br_taken) begin
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = i_ex_target;
                end else if (i_dec_ce && exc_any) begin
                    // MRET keeps the saved EPC and cause so the return can use them.
                    flush        = 1'b1;
                    state_next   = DRAIN;
                    is_mret_next = !exc_trap;
                    if (exc_trap) begin
                        epc_next = i_dec_pc;
                        if (i_dec_exc[`ILLEGAL])     cause_next = 4'd2;
                        else if (i_dec_exc[`EBREAK]) cause_next = 4'd3;
                        else                         cause_next = 4'd11;
                    end
                end else if (hazard) begin
                    stall          = 1'b1;
                    stall_cnt_next = LAT_M1;
                    state_next     = (LOAD_LAT == 1) ? RUN : LSTALL;
                end
            end
            LSTALL: begin
                if (i_ex_br_taken) begin
                    flush          = 1'b1;
                    redirect       = 1'b1;
                    redirect_pc    = i_ex_target;
                    stall_cnt_next = '0;
                    state_next     = RUN;
                end else if (stall_cnt == '0) begin
                    state_next = RUN;
                end else begin
                    stall          = 1'b1;
                    stall_cnt_next = stall_cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (i_ex_br_taken) begin
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    redirect_pc = i_ex_target;
                    state_next  = RUN;
                end else begin
                    stall = 1'b1;
                    flush = 1'b1;
                    if (inflight == '0) state_next = TRAP;
                end
            end
            TRAP: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = is_mret ? o_epc : TRAP_VECTOR;
                state_next  = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Outputs are forced low while reset is held, regardless of pipeline inputs.
    assign o_stall       = d_rst & stall;
    assign o_flush       = d_rst & flush;
    assign o_redirect    = d_rst & redirect;
    assign o_redirect_pc = d_rst ? redirect_pc : '0;
    assign o_busy        = d_rst & (state != RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the hazard/trap rules.
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef ILLEGAL
`define ILLEGAL 0
`endif
`ifndef ECALL
`define ECALL 1
`endif
`ifndef EBREAK
`define EBREAK 2
`endif
`ifndef MRET
`define MRET 3
`endif

module tb_pipeline_ctrl;

    localparam int LOAD_LAT = 2;
    localparam logic [31:0] VEC = 32'h0000_0100;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic        i_dec_ce = 1'b0;
    logic [4:0]  i_dec_rs1 = '0;
    logic [4:0]  i_dec_rs2 = '0;
    logic [3:0]  i_dec_exc = '0;
    logic [31:0] i_dec_pc = '0;
    logic        i_ex_issue = 1'b0;
    logic        i_ex_load = 1'b0;
    logic [4:0]  i_ex_rd = '0;
    logic        i_ex_br_taken = 1'b0;
    logic [31:0] i_ex_target = '0;
    logic        i_wb_retire = 1'b0;
    logic        o_stall, o_flush, o_redirect, o_busy;
    logic [31:0] o_redirect_pc, o_epc;
    logic [3:0]  o_cause;

    int total = 0;
    int bad = 0;

    pipeline_ctrl #(.LOAD_LAT(LOAD_LAT)) dut (
        .d_clk(d_clk), .d_rst(d_rst), .i_dec_ce(i_dec_ce), .i_dec_rs1(i_dec_rs1),
        .i_dec_rs2(i_dec_rs2), .i_dec_exc(i_dec_exc), .i_dec_pc(i_dec_pc),
        .i_ex_issue(i_ex_issue), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
        .i_ex_br_taken(i_ex_br_taken), .i_ex_target(i_ex_target), .i_wb_retire(i_wb_retire),
        .o_stall(o_stall), .o_flush(o_flush), .o_redirect(o_redirect),
        .o_redirect_pc(o_redirect_pc), .o_epc(o_epc), .o_cause(o_cause), .o_busy(o_busy)
    );

    always #5 d_clk = ~d_clk;

    // Model: remaining post-hazard hold cycles, drain/vector flags, in-flight count.
    int          m_hold, m_inflight;
    bit          m_drain, m_vector, m_return;
    logic [31:0] m_epc;
    logic [3:0]  m_cause;
    logic        e_stall, e_flush, e_redir, e_busy;
    logic [31:0] e_pc, e_epc;
    logic [3:0]  e_cause;

    task automatic model_reset();
        m_hold = 0; m_inflight = 0; m_drain = 0; m_vector = 0; m_return = 0;
        m_epc = '0; m_cause = '0;
    endtask

    task automatic model_step();
        bit trap_kind, hz;
        trap_kind = i_dec_exc[`ILLEGAL] | i_dec_exc[`ECALL] | i_dec_exc[`EBREAK];
        hz = i_dec_ce && i_ex_load && (i_ex_rd != 0) &&
             (i_ex_rd == i_dec_rs1 || i_ex_rd == i_dec_rs2);
        e_stall = 0; e_flush = 0; e_redir = 0; e_pc = '0;
        e_busy = (m_hold > 0) || m_drain || m_vector;
        e_epc = m_epc; e_cause = m_cause;
        if (m_vector) begin
            e_redir = 1; e_flush = 1; e_pc = m_return ? m_epc : VEC; m_vector = 0;
        end else if (i_ex_br_taken) begin
            e_flush = 1; e_redir = 1; e_pc = i_ex_target; m_hold = 0; m_drain = 0;
        end else if (m_drain) begin
            e_stall = 1; e_flush = 1;
            if (m_inflight == 0) begin m_drain = 0; m_vector = 1; end
        end else if (m_hold > 0) begin
            e_stall = (m_hold > 1); m_hold--;
        end else if (i_dec_ce && (trap_kind || i_dec_exc[`MRET])) begin
            e_flush = 1; m_drain = 1; m_return = !trap_kind;
            if (trap_kind) begin
                m_epc = i_dec_pc;
                m_cause = i_dec_exc[`ILLEGAL] ? 4'd2 : (i_dec_exc[`EBREAK] ? 4'd3 : 4'd11);
            end
        end else if (hz) begin
            e_stall = 1; m_hold = (LOAD_LAT == 1) ? 0 : LOAD_LAT;
        end
        if (i_ex_issue && !i_wb_retire && m_inflight < 7) m_inflight++;
        if (i_wb_retire && !i_ex_issue && m_inflight > 0) m_inflight--;
    endtask

    task automatic idle_inputs();
        i_dec_ce = 0; i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_exc = '0; i_dec_pc = '0;
        i_ex_issue = 0; i_ex_load = 0; i_ex_rd = '0; i_ex_br_taken = 0;
        i_ex_target = '0; i_wb_retire = 0;
    endtask

    task automatic settle();
        #1;
        model_step();
    endtask

    task automatic advance();
        @(posedge d_clk);
        @(negedge d_clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        d_rst = 0;
        model_reset();
        repeat (2) @(negedge d_clk);
        d_rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        d_rst = 0;
        i_ex_br_taken = 1; i_ex_target = 32'h1234;
        #1;
        total++;
        if ({o_stall, o_flush, o_redirect, o_busy, o_redirect_pc, o_epc, o_cause} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b/%b/%b/%b pc=%0h epc=%0h cause=%0d want all 0",
                     o_stall, o_flush, o_redirect, o_busy, o_redirect_pc, o_epc, o_cause);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        logic want_stall [3] = '{1'b1, 1'b1, 1'b0};
        i_dec_ce = 1; i_ex_load = 1; i_ex_rd = 5'd5; i_dec_rs1 = 5'd1; i_dec_rs2 = 5'd5;
        for (int c = 0; c < 3; c++) begin
            settle();
            total++;
            if (o_stall !== want_stall[c] || o_flush !== 1'b0) begin
                bad++;
                $display("[TB] FAIL load_use_c%0d stall=%b flush=%b want stall=%b flush=0",
                         c, o_stall, o_flush, want_stall[c]);
            end
            advance();
            i_ex_load = 0; i_ex_rd = '0;
        end
        idle_inputs();
        settle();
        total++;
        if (o_busy !== 1'b0 || o_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL load_use_end busy=%b stall=%b want 0/0", o_busy, o_stall);
        end
        advance();
    endtask

    task automatic test_rd_zero();
        i_dec_ce = 1; i_ex_load = 1; i_ex_rd = '0; i_dec_rs1 = '0; i_dec_rs2 = 5'd3;
        settle();
        total++;
        if (o_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_zero stall=%b want 0", o_stall);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_branch_hazard();
        i_dec_ce = 1; i_ex_load = 1; i_ex_rd = 5'd7; i_dec_rs1 = 5'd7;
        i_ex_br_taken = 1; i_ex_target = 32'h0000_2468;
        settle();
        total++;
        if (o_flush !== 1'b1 || o_redirect !== 1'b1 || o_stall !== 1'b0 ||
            o_redirect_pc !== 32'h0000_2468) begin
            bad++;
            $display("[TB] FAIL branch_hazard flush=%b redir=%b stall=%b pc=%0h want 1/1/0 pc=2468",
                     o_flush, o_redirect, o_stall, o_redirect_pc);
        end
        advance();
        idle_inputs();
    endtask

    // Idle until a redirect appears (bounded), then check its target.
    task automatic wait_redirect(input string name, input logic [31:0] want_pc);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (o_redirect === 1'b1) begin seen = 1; break; end
            advance();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL %s_timeout got no redirect want pc=%0h", name, want_pc);
        end else if (o_redirect_pc !== want_pc || o_flush !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_pc got=%0h flush=%b want=%0h flush=1",
                     name, o_redirect_pc, o_flush, want_pc);
        end
        advance();
        settle();
        total++;
        if (o_redirect !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_after redir=%b busy=%b want 0/0", name, o_redirect, o_busy);
        end
        advance();
    endtask

    task automatic test_ecall_trap();
        i_ex_issue = 1; settle(); advance();
        settle(); advance();
        i_ex_issue = 0;
        i_dec_ce = 1; i_dec_exc = 4'b0010; i_dec_pc = 32'h40;
        settle();
        total++;
        if (o_flush !== 1'b1 || o_stall !== 1'b0 || o_redirect !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ecall_entry flush=%b stall=%b redir=%b want 1/0/0",
                     o_flush, o_stall, o_redirect);
        end
        advance();
        idle_inputs();
        for (int r = 0; r < 3; r++) begin
            i_wb_retire = (r < 2);
            settle();
            total++;
            if (o_stall !== 1'b1 || o_flush !== 1'b1 || o_busy !== 1'b1 || o_redirect !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ecall_drain_%0d stall=%b flush=%b busy=%b redir=%b want 1/1/1/0",
                         r, o_stall, o_flush, o_busy, o_redirect);
            end
            advance();
        end
        idle_inputs();
        total++;
        if (o_epc !== 32'h40 || o_cause !== 4'd11) begin
            bad++;
            $display("[TB] FAIL ecall_epc_cause epc=%0h cause=%0d want 40/11", o_epc, o_cause);
        end
        wait_redirect("ecall_vec", VEC);
    endtask

    task automatic test_mret();
        i_ex_issue = 1; settle(); advance();
        i_ex_issue = 0;
        i_dec_ce = 1; i_dec_exc = 4'b1000; i_dec_pc = 32'h120;
        settle(); advance();
        idle_inputs();
        i_wb_retire = 1; settle(); advance();
        i_wb_retire = 0;
        wait_redirect("mret_ret", 32'h40);
        total++;
        if (o_epc !== 32'h40 || o_cause !== 4'd11) begin
            bad++;
            $display("[TB] FAIL mret_keep epc=%0h cause=%0d want 40/11", o_epc, o_cause);
        end
    endtask

    task automatic test_cause_priority();
        i_dec_ce = 1; i_dec_exc = 4'b0101; i_dec_pc = 32'h80;
        settle(); advance();
        idle_inputs();
        total++;
        if (o_cause !== 4'd2 || o_epc !== 32'h80) begin
            bad++;
            $display("[TB] FAIL cause_priority cause=%0d epc=%0h want 2/80", o_cause, o_epc);
        end
        wait_redirect("illegal_vec", VEC);
    endtask

    task automatic test_branch_in_drain();
        i_ex_issue = 1; settle(); advance();
        i_ex_issue = 0;
        i_dec_ce = 1; i_dec_exc = 4'b0100; i_dec_pc = 32'h90;
        settle(); advance();
        idle_inputs();
        settle(); advance();
        i_ex_br_taken = 1; i_ex_target = 32'h0000_3000;
        settle();
        total++;
        if (o_redirect !== 1'b1 || o_flush !== 1'b1 || o_redirect_pc !== 32'h3000) begin
            bad++;
            $display("[TB] FAIL drain_branch redir=%b flush=%b pc=%0h want 1/1/3000",
                     o_redirect, o_flush, o_redirect_pc);
        end
        advance();
        idle_inputs();
        settle();
        total++;
        if (o_busy !== 1'b0 || o_redirect !== 1'b0 || o_epc !== 32'h90 || o_cause !== 4'd3) begin
            bad++;
            $display("[TB] FAIL drain_abandon busy=%b redir=%b epc=%0h cause=%0d want 0/0/90/3",
                     o_busy, o_redirect, o_epc, o_cause);
        end
        advance();
        i_wb_retire = 1; settle(); advance();
        idle_inputs();
    endtask

    task automatic test_reset_in_lstall();
        i_dec_ce = 1; i_ex_load = 1; i_ex_rd = 5'd9; i_dec_rs2 = 5'd9;
        settle(); advance();
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lstall_entry busy=%b want 1", o_busy);
        end
        d_rst = 0;
        #1;
        total++;
        if ({o_stall, o_flush, o_redirect, o_busy, o_redirect_pc, o_epc, o_cause} !== '0) begin
            bad++;
            $display("[TB] FAIL lstall_reset stall=%b flush=%b redir=%b busy=%b epc=%0h cause=%0d want all 0",
                     o_stall, o_flush, o_redirect, o_busy, o_epc, o_cause);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [72:0] got, want;
        for (int c = 0; c < 1500; c++) begin
            i_dec_ce = ($urandom_range(0, 3) != 0);
            i_dec_rs1 = 5'($urandom_range(0, 3));
            i_dec_rs2 = 5'($urandom_range(0, 3));
            i_dec_exc = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            i_dec_pc = {$urandom} & 32'hFFFF_FFFC;
            i_ex_issue = $urandom_range(0, 1);
            i_wb_retire = ($urandom_range(0, 2) != 0);
            i_ex_load = $urandom_range(0, 1);
            i_ex_rd = 5'($urandom_range(0, 3));
            i_ex_br_taken = ($urandom_range(0, 9) == 0);
            i_ex_target = $urandom;
            settle();
            got  = {o_stall, o_flush, o_redirect, o_busy, o_redirect_pc, o_epc, o_cause};
            want = {e_stall, e_flush, e_redir, e_busy, e_pc, e_epc, e_cause};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL random_c%0d got s/f/r/b=%b%b%b%b pc=%0h epc=%0h cause=%0d want %b%b%b%b pc=%0h epc=%0h cause=%0d",
                         c, o_stall, o_flush, o_redirect, o_busy, o_redirect_pc, o_epc, o_cause,
                         e_stall, e_flush, e_redir, e_busy, e_pc, e_epc, e_cause);
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch_hazard();
        test_ecall_trap();
        test_mret();
        test_cause_priority();
        test_branch_in_drain();
        test_reset_in_lstall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
